// File: rtl/fetch_unit.sv
// fetch_unit: one-outstanding-request instruction fetcher feeding an in-order queue to decode.
// Define FETCH_PERF_EN to build the FetchCnt/StallCnt performance counters.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int QDEPTH = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        LEn,
  output logic        RRdy,
  output logic [31:0] RAddr,
  input  logic        RVld,
  input  logic [31:0] RData,
  output logic        IVld,
  input  logic        IRdy,
  output logic [31:0] IData,
  output logic [31:0] IPc,
  input  logic        Redir,
  input  logic [31:0] RedirPc,
  output logic [31:0] FetchCnt,
  output logic [31:0] StallCnt
);
  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] QD = CW'(QDEPTH);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [CW-1:0] count, count_nxt;
  logic drop, drop_nxt;
  logic [AW-1:0] head, tail;
  logic [31:0] qdata [QDEPTH];
  logic [31:0] qpc [QDEPTH];
  logic push, pop;
  assign RRdy = state == REQ;
  assign RAddr = {2'b00, pc[31:2]};
  assign IVld = count != '0;
  assign IData = IVld ? qdata[head] : '0;
  assign IPc = IVld ? qpc[head] : '0;
  // a redirect flushes the queue, so it suppresses both the push and the pop
  assign push = state == WAIT && RVld && !Redir && !drop;
  assign pop = IVld && IRdy && !Redir;
  assign count_nxt = Redir ? '0 : count + CW'(push) - CW'(pop);
  assign pc_nxt = Redir ? RedirPc & 32'hFFFF_FFFC : push ? pc + 32'd4 : pc;
  always_comb begin
    state_nxt = state;
    drop_nxt = drop;
    case (state)
      IDLE: state_nxt = LEn && count < QD && !Redir ? REQ : IDLE;
      REQ: begin
        state_nxt = WAIT;
        drop_nxt = drop || Redir;
      end
      WAIT: begin
        state_nxt = !RVld ? WAIT : LEn && count_nxt < QD ? REQ : IDLE;
        drop_nxt = RVld ? 1'b0 : drop || Redir;
      end
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      pc <= RESET_PC;
      count <= '0;
      drop <= 1'b0;
      head <= '0;
      tail <= '0;
    end else begin
      state <= state_nxt;
      pc <= pc_nxt;
      count <= count_nxt;
      drop <= drop_nxt;
      head <= Redir ? '0 : head + AW'(pop);
      tail <= Redir ? '0 : tail + AW'(push);
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      qdata[tail] <= RData;
      qpc[tail] <= pc;
    end
  end
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt, stall_cnt;
  always_ff @(posedge clk) begin
    if (!rstn) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      fetch_cnt <= fetch_cnt + 32'(push);
      stall_cnt <= stall_cnt + 32'(IVld && !IRdy);
    end
  end
  assign FetchCnt = fetch_cnt;
  assign StallCnt = stall_cnt;
`else
  assign FetchCnt = '0;
  assign StallCnt = '0;
`endif
endmodule
